// File: rtl/mpc_pkg.sv
// Shared constants and types for the multi-port packet SRAM controller blocks.
package mpc_pkg;

   localparam int MPC_DWIDTH    = 32;
   localparam int MPC_NRAMWIDTH = 5;
   localparam int MPC_AWIDTH    = 13;
   localparam int MPC_ADDRW     = MPC_NRAMWIDTH + MPC_AWIDTH;

   typedef enum logic {
      ARB_UNLOCKED = 1'b0,
      ARB_LOCKED   = 1'b1
   } arb_state_e;

endpackage

// File: rtl/mpc_rr_pick.sv
// Combinational round-robin picker: first set request strictly after rr_ptr_i, wrapping.
module mpc_rr_pick #(
   parameter int NREQ = 4
) (
   input  logic [NREQ-1:0]         req_i,
   input  logic [$clog2(NREQ)-1:0] rr_ptr_i,
   output logic [NREQ-1:0]         gnt_o,
   output logic [$clog2(NREQ)-1:0] idx_o,
   output logic                    any_o
);
   localparam int PW = $clog2(NREQ);

   always_comb begin
      logic [PW-1:0] cand;
      logic          found;
      cand  = '0;
      found = 1'b0;
      gnt_o = '0;
      idx_o = '0;
      for (int k = 1; k <= NREQ; k++) begin
         cand = PW'((int'(rr_ptr_i) + k) % NREQ);
         if (!found && req_i[cand]) begin
            found       = 1'b1;
            gnt_o[cand] = 1'b1;
            idx_o       = cand;
         end
      end
      any_o = found;
   end

endmodule

// File: rtl/mpc_sram_port_arb.sv
// Round-robin arbiter in front of one packed-SRAM port, read data returned one cycle later.
// Burst locking is built only when MPC_ARB_BURST_LOCK_EN is defined.
//
// state        | meaning
// ARB_UNLOCKED | every beat re-arbitrates round-robin
// ARB_LOCKED   | owner keeps the port while it requests, up to MAXBURST beats
module mpc_sram_port_arb
   import mpc_pkg::*;
#(
   parameter int NREQ     = 4,
   parameter int DWIDTH   = MPC_DWIDTH,
   parameter int ADDRW    = MPC_ADDRW,
   parameter int MAXBURST = 16
) (
   input  logic                    clk_in,
   input  logic                    rst_in,
   input  logic [NREQ-1:0]         req_in,
   input  logic [NREQ-1:0]         we_in,
   input  logic [NREQ-1:0]         last_in,
   input  logic [NREQ*ADDRW-1:0]   addr_in,
   input  logic [NREQ*DWIDTH-1:0]  wdata_in,
   output logic [NREQ-1:0]         gnt_out,
   output logic [NREQ-1:0]         rvalid_out,
   output logic [DWIDTH-1:0]       rdata_out,
   output logic                    en_out,
   output logic                    we_out,
   output logic [ADDRW-1:0]        addr_out,
   output logic [DWIDTH-1:0]       d_out,
   input  logic [DWIDTH-1:0]       d_in
);
   localparam int PW = $clog2(NREQ);

   logic [PW-1:0]   rr_ptr_q, rr_ptr_d;
   logic [NREQ-1:0] pick_oh;
   logic [PW-1:0]   pick_idx;
   logic            pick_any;
   logic [NREQ-1:0] gnt;
   logic [PW-1:0]   win_idx;
   logic            win_any;
   logic [NREQ-1:0] rvalid_q;

   mpc_rr_pick #(.NREQ(NREQ)) u_pick (
      .req_i    (req_in),
      .rr_ptr_i (rr_ptr_q),
      .gnt_o    (pick_oh),
      .idx_o    (pick_idx),
      .any_o    (pick_any)
   );

`ifdef MPC_ARB_BURST_LOCK_EN
   localparam int CW = $clog2(MAXBURST);

   arb_state_e    state_q, state_d;
   logic [PW-1:0] owner_q, owner_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          hold;

   assign hold = (state_q == ARB_LOCKED) && req_in[owner_q];

   always_comb begin
      gnt     = pick_oh;
      win_idx = pick_idx;
      win_any = pick_any;
      if (hold) begin
         gnt          = '0;
         gnt[owner_q] = 1'b1;
         win_idx      = owner_q;
         win_any      = 1'b1;
      end
   end

   always_comb begin
      state_d  = state_q;
      owner_d  = owner_q;
      cnt_d    = cnt_q;
      rr_ptr_d = rr_ptr_q;
      if (hold) begin
         if (last_in[owner_q] || (cnt_q == CW'(MAXBURST - 1))) begin
            state_d  = ARB_UNLOCKED;
            rr_ptr_d = owner_q;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end else begin
         // An owner that drops its request frees the port in the same cycle.
         state_d = ARB_UNLOCKED;
         if (state_q == ARB_LOCKED) begin
            rr_ptr_d = owner_q;
         end
         if (pick_any) begin
            rr_ptr_d = pick_idx;
            if (!last_in[pick_idx]) begin
               state_d = ARB_LOCKED;
               owner_d = pick_idx;
               cnt_d   = CW'(1);
            end
         end
      end
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state_q <= ARB_UNLOCKED;
         owner_q <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         cnt_q   <= cnt_d;
      end
   end
`else
   logic unused_cfg;

   assign gnt        = pick_oh;
   assign win_idx    = pick_idx;
   assign win_any    = pick_any;
   assign unused_cfg = ^{last_in, (MAXBURST > 1)};

   always_comb begin
      rr_ptr_d = rr_ptr_q;
      if (pick_any) begin
         rr_ptr_d = pick_idx;
      end
   end
`endif

   always_comb begin
      en_out   = win_any;
      we_out   = 1'b0;
      addr_out = '0;
      d_out    = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (win_any && (win_idx == PW'(i))) begin
            we_out   = we_in[i];
            addr_out = addr_in[i*ADDRW +: ADDRW];
            d_out    = wdata_in[i*DWIDTH +: DWIDTH];
         end
      end
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         rr_ptr_q <= PW'(NREQ - 1);
         rvalid_q <= '0;
      end else begin
         rr_ptr_q <= rr_ptr_d;
         rvalid_q <= gnt & ~we_in;
      end
   end

   assign gnt_out    = gnt;
   assign rvalid_out = rvalid_q;
   assign rdata_out  = (|rvalid_q) ? d_in : '0;

endmodule

// File: doc/mpc_sram_port_arb.md
Name: mpc_sram_port_arb

Overview:
- Arbitrates NREQ requesters (read or write beats) onto a single port of the shared multi-bank packet SRAM.
- One instance sits in front of each SRAM port. It uses round-robin fairness and optional burst locking, so that a requester's consecutive beats stay contiguous.
- It returns read data one cycle after the read beat, with a valid strobe that goes only to the requester that issued the read.

Parameters:
- NREQ, 4, number of requesters (2..16).
- DWIDTH, 32, data width.
- ADDRW, 18, full SRAM address width (bank-select bits plus in-bank bits, 5+13).
- MAXBURST, 16, maximum beats one requester may hold the port while locked (power of 2, ≥2).

Ports:
- clk_in  input  1  clock
- rst_in  input  1  synchronous active-high reset
- req_in  input  NREQ  per-requester beat request
- we_in  input  NREQ  per-requester write (1) / read (0)
- last_in  input  NREQ  beat is final of requester's burst
- addr_in  input  NREQ*ADDRW  packed addresses; requester i at [i*ADDRW +: ADDRW]
- wdata_in  input  NREQ*DWIDTH  packed write data; requester i at [i*DWIDTH +: DWIDTH]
- gnt_out  output  NREQ  one-hot; beat of requester i accepted this cycle
- rvalid_out  output  NREQ  one-hot; read data for requester i valid this cycle
- rdata_out  output  DWIDTH  read data, shared by all requesters
- en_out  output  1  SRAM port enable
- we_out  output  1  SRAM port write enable
- addr_out  output  ADDRW  SRAM port address
- d_out  output  DWIDTH  SRAM write data
- d_in  input  DWIDTH  SRAM read data; valid one cycle after a read enable, zero otherwise

Behaviour:
- Reset:
  - gnt_out, rvalid_out, en_out and we_out are 0.
  - rr_ptr = NREQ-1, so requester 0 has first priority.
  - lock = 0, owner = 0, beat_cnt = 0.
- Grant is combinational from req_in and registered state. A beat is accepted in the cycle gnt_out[i]=1.
  - No backpressure toward the SRAM.
  - The requester holds req/we/addr/wdata/last stable until granted.
- Winner selection:
  - If lock=1 and req_in[owner]=1, the winner is owner.
  - Otherwise the winner is the first requester with req_in set, scanning from rr_ptr+1 upward and wrapping modulo NREQ.
  - If no requester has req_in set, there is no winner.
- SRAM drive:
  - en_out=1 iff there is a winner.
  - we_out, addr_out and d_out are the winner's we_in, addr_in and wdata_in.
  - When there is no winner, all four outputs are 0.
- Lock (burst) state machine, two states, updated on each clock edge:
  - UNLOCKED -> LOCKED when the granted beat has last=0. owner is set to the winner and beat_cnt is set to 1.
  - LOCKED -> LOCKED on an owner beat with last=0 and beat_cnt < MAXBURST-1; beat_cnt increments.
  - LOCKED -> UNLOCKED on any of the following; in each case rr_ptr is set to owner:
    - owner beat with last=1;
    - owner beat with beat_cnt = MAXBURST-1, i.e. the forced release on the MAXBURST-th beat;
    - req_in[owner]=0 (owner dropped its request).
  - The cycle in which the owner drops its request is a normal arbitration cycle with no bubble.
- rr_ptr also updates to the winner on every unlocked grant, including single-beat grants.
- Read return:
  - rvalid_out is a registered copy of (gnt_out AND NOT we_in): one-cycle latency.
  - rdata_out = d_in when any rvalid_out bit is set, else 0.
- Back-to-back reads from different requesters return in grant order, one per cycle.
- Reset mid-burst: lock is cleared and any pending rvalid is discarded; the read data is lost and the requester reissues the read.
- Width rules:
  - beat_cnt is $clog2(MAXBURST) bits.
  - rr_ptr and owner are $clog2(NREQ) bits; NREQ=1 is not supported.

Optional Feature:
- Macro: MPC_ARB_BURST_LOCK_EN.
- Defined: lock/burst behaviour exactly as described above.
- Undefined:
  - lock is held at 0 and last_in is ignored.
  - MAXBURST is unused.
  - Every beat re-arbitrates round-robin (beat-interleaved fairness).
  - beat_cnt, owner and lock registers are not generated.

Decomposition:
- Package mpc_pkg holds:
  - the default constants MPC_DWIDTH=32, MPC_NRAMWIDTH=5, MPC_AWIDTH=13, MPC_ADDRW=18;
  - typedef arb_state_e {ARB_UNLOCKED, ARB_LOCKED}.
- One sub-module, mpc_rr_pick: a pure combinational round-robin picker.
  - Inputs: req vector and rr_ptr.
  - Outputs: one-hot winner, winner index and any-flag.
  - Reused by the later ingress arbiters.

Test Plan:
1. Reset, then req_in=4'b1111, all reads, last=1 -> grants 0,1,2,3,0 in consecutive cycles; rvalid_out follows each grant by exactly 1 cycle with rdata_out = model SRAM data.
2. Lock enabled; requester 2 writes a 3-beat burst (last on beat 3) while req 0 and 1 are asserted -> gnt_out=4'b0100 for 3 cycles, then 4'b0001; SRAM sees addr 0x00100,0x00101,0x00102 contiguous.
3. Requester 1 bursts with last=0 permanently, MAXBURST=16, req 3 pending -> exactly 16 grants to req 1, then req 3 granted on cycle 17.
4. Owner 0 deasserts req after 2 beats of an unterminated burst, req 2 pending -> req 2 granted in the same cycle, no idle cycle; en_out stays 1.
5. rst_in asserted during a locked read burst, the cycle after a read grant -> rvalid_out=0 next cycle; after release, req_in=4'b1000 plus 4'b0001 gives requester 0 first priority.
6. Lock disabled (macro undefined); req 0 and req 1 both hold last=0 -> gnt alternates 0,1,0,1; last_in has no effect.
